// File: rtl/vx_smem_responder.sv
// vx_smem_responder
//   Far end of the core's shared-memory request/response bus. Captures one
//   batch of per-lane load/store requests, serializes the lane accesses over
//   word-interleaved banks (one access per bank per cycle), and returns a
//   single merged read response for the batch.
//
//   Ports
//     clk, reset    clock, asynchronous active-high reset
//     req_valid     per-lane request valid
//     req_rw        per-lane 1=store, 0=load
//     req_byteen    per-lane store byte enables
//     req_addr      per-lane word address (upper bits above the storage index ignored)
//     req_data      per-lane store data
//     req_tag       per-lane tag
//     req_ready     per-lane ready, all bits equal, high only in IDLE
//     rsp_valid     merged response valid
//     rsp_tmask     lanes carrying load data
//     rsp_data      per-lane load data (0 in lanes outside rsp_tmask)
//     rsp_tag       tag of the lowest-index accepted lane
//     rsp_ready     response accepted
//
//   Optional build macro: SMEM_RD_BCAST_EN
//     When defined, pending loads hitting the same word as a bank's selected
//     load are served in the same cycle. Stores are never broadcast.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | ready for a batch; accepts on any req_valid bit
//   ACCESS | one access per bank per cycle until no lane is pending
//   RSP    | merged read response presented until rsp_ready

module vx_smem_responder #(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 4,
  parameter int SIZE      = 4096,
  parameter int WORD_SIZE = 4,
  parameter int ADDRW     = 30,
  parameter int TAG_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
  input  logic [NUM_REQS*ADDRW-1:0]       req_addr,
  input  logic [NUM_REQS*WORD_SIZE*8-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  output logic                            rsp_valid,
  output logic [NUM_REQS-1:0]             rsp_tmask,
  output logic [NUM_REQS*WORD_SIZE*8-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  input  logic                            rsp_ready
);

  localparam int WORD_W     = WORD_SIZE * 8;
  localparam int NUM_WORDS  = SIZE / WORD_SIZE;
  localparam int IDXW       = $clog2(NUM_WORDS);
  localparam int BANKW      = $clog2(NUM_BANKS);
  localparam int ROWW       = IDXW - BANKW;
  localparam int BANK_WORDS = NUM_WORDS / NUM_BANKS;
  localparam int LANEW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RSP} state_e;

  state_e state_q, state_d;

  logic [NUM_REQS-1:0]  pend_q, pend_d;
  logic [NUM_REQS-1:0]  rmask_q, rmask_d;
  logic [NUM_REQS-1:0]  rw_q, rw_d;
  logic [IDXW-1:0]      idx_q [NUM_REQS];
  logic [IDXW-1:0]      idx_d [NUM_REQS];
  logic [WORD_SIZE-1:0] be_q [NUM_REQS];
  logic [WORD_SIZE-1:0] be_d [NUM_REQS];
  logic [WORD_W-1:0]    wdata_q [NUM_REQS];
  logic [WORD_W-1:0]    wdata_d [NUM_REQS];
  logic [WORD_W-1:0]    rdata_q [NUM_REQS];
  logic [WORD_W-1:0]    rdata_d [NUM_REQS];
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  // Storage is split into word-interleaved banks, one write port each.
  logic [WORD_W-1:0] bank_mem [NUM_BANKS][BANK_WORDS];

  logic                 accept;
  logic [BANKW-1:0]     lane_bank [NUM_REQS];
  logic [ROWW-1:0]      lane_row  [NUM_REQS];
  logic [NUM_BANKS-1:0] sel_vld;
  logic [LANEW-1:0]     sel_lane [NUM_BANKS];
  logic [NUM_REQS-1:0]  served;
  logic [NUM_BANKS-1:0] wr_en;
  logic [ROWW-1:0]      wr_row  [NUM_BANKS];
  logic [WORD_SIZE-1:0] wr_be   [NUM_BANKS];
  logic [WORD_W-1:0]    wr_data [NUM_BANKS];
  logic                 unused_addr_hi;

  assign accept = (state_q == S_IDLE) && (|req_valid);

  // Address bits above the storage index wrap and are deliberately dropped.
  always_comb begin
    unused_addr_hi = 1'b0;
    for (int l = 0; l < NUM_REQS; l++) begin
      unused_addr_hi = unused_addr_hi ^ (^req_addr[l*ADDRW+IDXW +: ADDRW-IDXW]);
    end
  end

  always_comb begin
    for (int l = 0; l < NUM_REQS; l++) begin
      lane_bank[l] = idx_q[l][BANKW-1:0];
      lane_row[l]  = idx_q[l][IDXW-1:BANKW];
    end
  end

  // Lowest-index pending lane per bank; scanning downward lets the lowest win.
  always_comb begin
    sel_vld = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      sel_lane[b] = '0;
    end
    for (int l = NUM_REQS - 1; l >= 0; l--) begin
      if (pend_q[l]) begin
        sel_vld[lane_bank[l]]  = 1'b1;
        sel_lane[lane_bank[l]] = LANEW'(l);
      end
    end
  end

`ifdef SMEM_RD_BCAST_EN
  logic bcast_blk;
`endif

  always_comb begin
    served = '0;
    for (int l = 0; l < NUM_REQS; l++) begin
      if (pend_q[l] && (sel_lane[lane_bank[l]] == LANEW'(l))) served[l] = 1'b1;
    end
`ifdef SMEM_RD_BCAST_EN
    bcast_blk = 1'b0;
    // A pending store to the same word stops the broadcast for all higher
    // lanes, so those loads still observe that store first.
    for (int b = 0; b < NUM_BANKS; b++) begin
      bcast_blk = 1'b0;
      if (sel_vld[b] && !rw_q[sel_lane[b]]) begin
        for (int l = 0; l < NUM_REQS; l++) begin
          if (pend_q[l] && (lane_bank[l] == BANKW'(b)) &&
              (lane_row[l] == lane_row[sel_lane[b]])) begin
            if (rw_q[l])         bcast_blk = 1'b1;
            else if (!bcast_blk) served[l] = 1'b1;
          end
        end
      end
    end
`endif
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_en[b]   = (state_q == S_ACCESS) && sel_vld[b] && rw_q[sel_lane[b]];
      wr_row[b]  = lane_row[sel_lane[b]];
      wr_be[b]   = be_q[sel_lane[b]];
      wr_data[b] = wdata_q[sel_lane[b]];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int by = 0; by < WORD_SIZE; by++) begin
        if (wr_en[b] && wr_be[b][by]) begin
          bank_mem[b][wr_row[b]][by*8 +: 8] <= wr_data[b][by*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    rmask_d = rmask_q;
    rw_d    = rw_q;
    tag_d   = tag_q;
    for (int l = 0; l < NUM_REQS; l++) begin
      idx_d[l]   = idx_q[l];
      be_d[l]    = be_q[l];
      wdata_d[l] = wdata_q[l];
      rdata_d[l] = rdata_q[l];
    end
    if (accept) begin
      pend_d  = req_valid;
      rmask_d = req_valid & ~req_rw;
      rw_d    = req_rw;
      for (int l = 0; l < NUM_REQS; l++) begin
        idx_d[l]   = req_addr[l*ADDRW +: IDXW];
        be_d[l]    = req_byteen[l*WORD_SIZE +: WORD_SIZE];
        wdata_d[l] = req_data[l*WORD_W +: WORD_W];
        rdata_d[l] = '0;
      end
      for (int l = NUM_REQS - 1; l >= 0; l--) begin
        if (req_valid[l]) tag_d = req_tag[l*TAG_WIDTH +: TAG_WIDTH];
      end
    end else if (state_q == S_ACCESS) begin
      pend_d = pend_q & ~served;
      for (int l = 0; l < NUM_REQS; l++) begin
        if (served[l] && !rw_q[l]) rdata_d[l] = bank_mem[lane_bank[l]][lane_row[l]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      rmask_q <= '0;
      rw_q    <= '0;
      tag_q   <= '0;
      for (int l = 0; l < NUM_REQS; l++) begin
        idx_q[l]   <= '0;
        be_q[l]    <= '0;
        wdata_q[l] <= '0;
        rdata_q[l] <= '0;
      end
    end else begin
      pend_q  <= pend_d;
      rmask_q <= rmask_d;
      rw_q    <= rw_d;
      tag_q   <= tag_d;
      for (int l = 0; l < NUM_REQS; l++) begin
        idx_q[l]   <= idx_d[l];
        be_q[l]    <= be_d[l];
        wdata_q[l] <= wdata_d[l];
        rdata_q[l] <= rdata_d[l];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req_valid) state_d = S_ACCESS;
      S_ACCESS: if ((pend_q & ~served) == '0) state_d = (rmask_q != '0) ? S_RSP : S_IDLE;
      S_RSP:    if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = {NUM_REQS{state_q == S_IDLE}};
    rsp_valid = (state_q == S_RSP);
    rsp_tmask = rsp_valid ? rmask_q : '0;
    rsp_tag   = rsp_valid ? tag_q : '0;
    rsp_data  = '0;
    for (int l = 0; l < NUM_REQS; l++) begin
      rsp_data[l*WORD_W +: WORD_W] = rsp_valid ? rdata_q[l] : '0;
    end
  end

endmodule

// File: tb/tb_vx_smem_responder.sv
`timescale 1ns/1ps
module tb_vx_smem_responder;
  localparam int NR = 4;
  localparam int NB = 4;
  localparam int SIZE = 4096;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int DW = 32;
  localparam int WORDS = SIZE / WS;
  localparam int IDXW = 10;
  localparam int MAXWAIT = 20;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req_valid, req_rw, req_ready, rsp_tmask;
  logic [NR*WS-1:0] req_byteen;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data, rsp_data;
  logic [NR*TW-1:0] req_tag;
  logic rsp_valid, rsp_ready;
  logic [TW-1:0] rsp_tag;

  vx_smem_responder #(.NUM_REQS(NR), .NUM_BANKS(NB), .SIZE(SIZE), .WORD_SIZE(WS),
                      .ADDRW(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_byteen(req_byteen), .req_addr(req_addr), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: flat word array, lanes applied in ascending index order.
  logic [DW-1:0] model_mem [WORDS];
  logic [NR-1:0] exp_mask;
  logic [NR*DW-1:0] exp_data;
  logic [TW-1:0] exp_tag;
  int exp_d;

  logic [NR-1:0] b_v, b_rw;
  logic [NR*WS-1:0] b_be;
  logic [NR*AW-1:0] b_addr;
  logic [NR*DW-1:0] b_data;
  logic [NR*TW-1:0] b_tag;

  int obs_lat;
  logic obs_rsp, obs_during_ok, obs_stable, obs_after_valid;
  logic [NR-1:0] obs_mask, obs_after_ready;
  logic [NR*DW-1:0] obs_data;
  logic [TW-1:0] obs_tag;

  task automatic clear_batch();
    b_v = '0; b_rw = '0; b_be = '0; b_addr = '0; b_data = '0; b_tag = '0;
  endtask

  task automatic set_lane(input int l, input logic rw, input logic [WS-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
    b_v[l] = 1'b1;
    b_rw[l] = rw;
    b_be[l*WS +: WS] = be;
    b_addr[l*AW +: AW] = a;
    b_data[l*DW +: DW] = d;
    b_tag[l*TW +: TW] = t;
  endtask

  task automatic model_batch();
    int cnt [NB];
    logic tag_set;
    logic [AW-1:0] a;
    int w;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    exp_mask = '0; exp_data = '0; exp_tag = '0; exp_d = 0; tag_set = 1'b0;
    for (int l = 0; l < NR; l++) begin
      if (b_v[l]) begin
        a = b_addr[l*AW +: AW];
        w = int'(a[IDXW-1:0]);
        cnt[w % NB]++;
        if (!tag_set) begin exp_tag = b_tag[l*TW +: TW]; tag_set = 1'b1; end
        if (b_rw[l]) begin
          for (int by = 0; by < WS; by++)
            if (b_be[l*WS + by]) model_mem[w][by*8 +: 8] = b_data[l*DW + by*8 +: 8];
        end else begin
          exp_mask[l] = 1'b1;
          exp_data[l*DW +: DW] = model_mem[w];
        end
      end
    end
    for (int b = 0; b < NB; b++) if (cnt[b] > exp_d) exp_d = cnt[b];
  endtask

  // Drives one batch, records what the DUT does; callers compare.
  task automatic send_batch(input int hold);
    int cyc;
    logic found;
    req_valid = b_v; req_rw = b_rw; req_byteen = b_be;
    req_addr = b_addr; req_data = b_data; req_tag = b_tag;
    @(posedge clk); #1;
    req_valid = '0;
    obs_during_ok = 1'b1; obs_lat = -1; found = 1'b0; cyc = 1;
    while (!found && cyc <= MAXWAIT) begin
      if (rsp_valid || req_ready == '1) begin
        found = 1'b1; obs_lat = cyc;
      end else begin
        if (req_ready !== '0) obs_during_ok = 1'b0;
        @(posedge clk); #1; cyc++;
      end
    end
    obs_rsp = rsp_valid; obs_mask = rsp_tmask; obs_data = rsp_data; obs_tag = rsp_tag;
    obs_stable = 1'b1;
    if (rsp_valid) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (rsp_valid !== 1'b1 || rsp_data !== obs_data || rsp_tag !== obs_tag ||
            rsp_tmask !== obs_mask || req_ready !== '0) obs_stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
    obs_after_valid = rsp_valid;
    obs_after_ready = req_ready;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL reset_req_ready: got %b want 1111", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_tmask !== '0) begin errors++; $display("FAIL reset_rsp_tmask: got %b want 0", rsp_tmask); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag: got %h want 0", rsp_tag); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL post_reset_ready: got %b want 1111", req_ready); end
  endtask

  task automatic test_preload();
    for (int k = 0; k < 16; k++) begin
      clear_batch();
      for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 4'hF, AW'(4*k + l), $urandom, 8'h00);
      model_batch();
      send_batch(0);
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL preload_lat: got %0d want 2", obs_lat); end
      checks++; if (obs_rsp !== 1'b0) begin errors++; $display("FAIL preload_norsp: got %b want 0", obs_rsp); end
    end
  endtask

  task automatic test_bank_conflict();
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 4'hF, AW'(4*l), 32'h10 * (l + 1), 8'h00);
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 5 || obs_rsp !== 1'b0) begin errors++; $display("FAIL conflict_store: lat %0d rsp %b want lat 5 rsp 0", obs_lat, obs_rsp); end
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(4*l), 32'h0, 8'h20 + 8'(l));
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 5) begin errors++; $display("FAIL conflict_load_lat: got %0d want 5", obs_lat); end
    checks++; if (obs_data !== {32'h40, 32'h30, 32'h20, 32'h10}) begin errors++; $display("FAIL conflict_load_data: got %h want 00000040000000300000002000000010", obs_data); end
    checks++; if (obs_tag !== 8'h20) begin errors++; $display("FAIL conflict_load_tag: got %h want 20", obs_tag); end
  endtask

  task automatic test_store_parallel();
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 4'hF, AW'(l), 32'hA0 + l, 8'h00);
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL store_par_lat: got %0d want 2", obs_lat); end
    checks++; if (obs_during_ok !== 1'b1) begin errors++; $display("FAIL store_par_busy_ready: got %b want 1", obs_during_ok); end
    checks++; if (obs_rsp !== 1'b0) begin errors++; $display("FAIL store_par_norsp: got %b want 0", obs_rsp); end
  endtask

  task automatic test_load_parallel();
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(l), 32'h0, 8'h31 + 8'(l));
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL load_par_lat: got %0d want 2", obs_lat); end
    checks++; if (obs_mask !== 4'b1111) begin errors++; $display("FAIL load_par_mask: got %b want 1111", obs_mask); end
    checks++; if (obs_data !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin errors++; $display("FAIL load_par_data: got %h want 000000a3000000a2000000a1000000a0", obs_data); end
    checks++; if (obs_tag !== 8'h31) begin errors++; $display("FAIL load_par_tag: got %h want 31", obs_tag); end
    checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 4'b1111) begin errors++; $display("FAIL load_par_handshake: valid %b ready %b want 0 1111", obs_after_valid, obs_after_ready); end
  endtask

  task automatic test_bcast();
    int want_lat;
`ifdef SMEM_RD_BCAST_EN
    want_lat = 2;
`else
    want_lat = 5;
`endif
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(0), 32'h0, 8'h40 + 8'(l));
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== want_lat) begin errors++; $display("FAIL same_word_lat: got %0d want %0d", obs_lat, want_lat); end
    checks++; if (obs_data !== {4{32'hA0}}) begin errors++; $display("FAIL same_word_data: got %h want 4x000000a0", obs_data); end
  endtask

  task automatic test_partial_store();
    int want_lat;
`ifdef SMEM_RD_BCAST_EN
    want_lat = 2;
`else
    want_lat = 3;
`endif
    clear_batch();
    set_lane(0, 1'b1, 4'h1, AW'(5), 32'h11, 8'h00);
    set_lane(2, 1'b1, 4'h3, AW'(5), 32'h2222, 8'h00);
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 3 || obs_rsp !== 1'b0) begin errors++; $display("FAIL partial_store: lat %0d rsp %b want lat 3 rsp 0", obs_lat, obs_rsp); end
    clear_batch();
    set_lane(1, 1'b0, 4'h0, AW'(5), 32'h0, 8'h5A);
    set_lane(3, 1'b0, 4'h0, AW'(5), 32'h0, 8'h5B);
    model_batch();
    send_batch(3);
    checks++; if (obs_lat !== want_lat) begin errors++; $display("FAIL partial_load_lat: got %0d want %0d", obs_lat, want_lat); end
    checks++; if (obs_data[DW +: 16] !== 16'h2222) begin errors++; $display("FAIL partial_low16: got %h want 2222", obs_data[DW +: 16]); end
    checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL partial_data: got %h want %h", obs_data, exp_data); end
    checks++; if (obs_mask !== 4'b1010) begin errors++; $display("FAIL partial_mask: got %b want 1010", obs_mask); end
    checks++; if (obs_tag !== 8'h5A) begin errors++; $display("FAIL partial_tag: got %h want 5a", obs_tag); end
    checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL partial_hold_stable: got %b want 1", obs_stable); end
    checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 4'b1111) begin errors++; $display("FAIL partial_handshake: valid %b ready %b want 0 1111", obs_after_valid, obs_after_ready); end
  endtask

  task automatic test_reset_mid_load();
    logic quiet;
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(4*l), 32'h0, 8'h70);
    req_valid = b_v; req_rw = b_rw; req_byteen = b_be; req_addr = b_addr; req_data = b_data; req_tag = b_tag;
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1111 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midload_reset_now: ready %b valid %b want 1111 0", req_ready, rsp_valid); end
    quiet = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (req_ready !== 4'b1111 || rsp_valid !== 1'b0) quiet = 1'b0; end
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (req_ready !== 4'b1111 || rsp_valid !== 1'b0) quiet = 1'b0; end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL midload_no_rsp: got %b want 1", quiet); end
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(l + 8), 32'h0, 8'h71);
    model_batch();
    send_batch(0);
    checks++; if (obs_lat !== 2 || obs_data !== exp_data) begin errors++; $display("FAIL midload_next: lat %0d data %h want 2 %h", obs_lat, obs_data, exp_data); end
  endtask

  task automatic test_reset_mid_store();
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b1, 4'hF, AW'(16 + 4*l), $urandom, 8'h00);
    req_valid = b_v; req_rw = b_rw; req_byteen = b_be; req_addr = b_addr; req_data = b_data; req_tag = b_tag;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    b_v = 4'b0011;  // only lanes 0 and 1 reach storage before reset
    model_batch();
    #1;
    checks++; if (req_ready !== 4'b1111 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midstore_reset_now: ready %b valid %b want 1111 0", req_ready, rsp_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_batch();
    for (int l = 0; l < NR; l++) set_lane(l, 1'b0, 4'h0, AW'(16 + 4*l), 32'h0, 8'h72);
    model_batch();
    send_batch(0);
    checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL midstore_contents: got %h want %h", obs_data, exp_data); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int it = 0; it < 60; it++) begin
      clear_batch();
      while (b_v == '0) begin
        for (int l = 0; l < NR; l++) begin
          if ($urandom_range(0, 3) != 0) begin
            a = AW'($urandom);
            a[IDXW-1:0] = IDXW'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 63));
            set_lane(l, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 8'($urandom));
          end
        end
      end
      model_batch();
      send_batch($urandom_range(0, 2));
      if (exp_mask != '0) begin
`ifdef SMEM_RD_BCAST_EN
        checks++; if (obs_lat < 2 || obs_lat > exp_d + 1) begin errors++; $display("FAIL rnd_lat it%0d: got %0d want 2..%0d", it, obs_lat, exp_d + 1); end
`else
        checks++; if (obs_lat !== exp_d + 1) begin errors++; $display("FAIL rnd_lat it%0d: got %0d want %0d", it, obs_lat, exp_d + 1); end
`endif
        checks++; if (obs_rsp !== 1'b1 || obs_mask !== exp_mask) begin errors++; $display("FAIL rnd_mask it%0d: rsp %b mask %b want 1 %b", it, obs_rsp, obs_mask, exp_mask); end
        checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd_data it%0d: got %h want %h", it, obs_data, exp_data); end
        checks++; if (obs_tag !== exp_tag) begin errors++; $display("FAIL rnd_tag it%0d: got %h want %h", it, obs_tag, exp_tag); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL rnd_stable it%0d: got %b want 1", it, obs_stable); end
        checks++; if (obs_after_valid !== 1'b0 || obs_after_ready !== 4'b1111) begin errors++; $display("FAIL rnd_handshake it%0d: valid %b ready %b want 0 1111", it, obs_after_valid, obs_after_ready); end
      end else begin
        checks++; if (obs_lat !== exp_d + 1 || obs_rsp !== 1'b0) begin errors++; $display("FAIL rnd_store it%0d: lat %0d rsp %b want %0d 0", it, obs_lat, obs_rsp, exp_d + 1); end
      end
      checks++; if (obs_during_ok !== 1'b1) begin errors++; $display("FAIL rnd_busy_ready it%0d: got %b want 1", it, obs_during_ok); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_rw = '0; req_byteen = '0; req_addr = '0; req_data = '0; req_tag = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_preload();
    test_bank_conflict();
    test_store_parallel();
    test_load_parallel();
    test_bcast();
    test_partial_store();
    test_reset_mid_load();
    test_reset_mid_store();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
